// File: rtl/cpu_reg_package.sv
// Shared CPU register-bus widths plus the timer register map and CTRL bit layout.
package cpu_reg_package;

  localparam int address_width = 16;
  localparam int data_width    = 16;

  localparam logic [address_width-1:0] TIMER_REG_CTRL     = 16'd0;
  localparam logic [address_width-1:0] TIMER_REG_LOAD     = 16'd1;
  localparam logic [address_width-1:0] TIMER_REG_PRESCALE = 16'd2;
  localparam logic [address_width-1:0] TIMER_REG_COUNT    = 16'd3;
  localparam logic [address_width-1:0] TIMER_REG_STATUS   = 16'd4;
  localparam logic [address_width-1:0] TIMER_NUM_REGS     = 16'd5;

  localparam int TIMER_CTRL_ENABLE_BIT      = 0;
  localparam int TIMER_CTRL_AUTO_RELOAD_BIT = 1;
  localparam int TIMER_CTRL_IRQ_EN_BIT      = 2;
  localparam int TIMER_STATUS_EXPIRED_BIT   = 0;

  // Field order mirrors the CTRL bit indices above (enable is the LSB).
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } timer_ctrl_t;

endpackage

// File: rtl/module_timer_if.sv
// Register-bus bundle between the CDC stage (master) and the timer (slave).
interface module_timer_if;
  import cpu_reg_package::*;

  logic                     bus_reset;
  logic                     we;
  logic [address_width-1:0] address;
  logic [data_width-1:0]    wr_dat;
  logic [data_width-1:0]    rd_dat;
  logic                     irq;

  modport master (output bus_reset, we, address, wr_dat, input rd_dat, irq);
  modport slave  (input bus_reset, we, address, wr_dat, output rd_dat, irq);
endinterface

// File: rtl/module_timer.sv
// Prescaled down-counter timer with a five-register bus map and registered IRQ.
// Read data appears one cycle after the read; writes commit at the access edge.
module module_timer
  import cpu_reg_package::*;
#(
  parameter logic [address_width-1:0] BASE_ADDRESS   = 16'h0100,
  parameter logic [data_width-1:0]    PRESCALE_RESET = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     bus_reset_i,
  input  logic                     we_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  output logic                     irq_o
);

  if (BASE_ADDRESS == '0) begin : g_bad_base
    $error("BASE_ADDRESS must be nonzero so the idle bus never hits a register");
  end

  timer_ctrl_t           ctrl_q, ctrl_d;
  logic [data_width-1:0] load_q, load_d;
  logic [data_width-1:0] prescale_q, prescale_d;
  logic [data_width-1:0] count_q, count_d;
  logic [data_width-1:0] pre_cnt_q, pre_cnt_d;
  logic                  expired_q, expired_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  irq_q, irq_d;

  logic [address_width-1:0] offset;
  logic in_range, wr, rd, tick;
  logic ctrl_wr, load_wr, prescale_wr, status_wr;

  // Offset compare avoids overflow when BASE_ADDRESS sits near the top of the map.
  assign offset      = address_i - BASE_ADDRESS;
  assign in_range    = (address_i >= BASE_ADDRESS) && (offset < TIMER_NUM_REGS);
  assign wr          = we_i & in_range;
  assign rd          = ~we_i & in_range;
  assign ctrl_wr     = wr && (offset == TIMER_REG_CTRL);
  assign load_wr     = wr && (offset == TIMER_REG_LOAD);
  assign prescale_wr = wr && (offset == TIMER_REG_PRESCALE);
  assign status_wr   = wr && (offset == TIMER_REG_STATUS);

  always_comb begin
    ctrl_d     = ctrl_q;
    load_d     = load_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    pre_cnt_d  = pre_cnt_q;
    expired_d  = expired_q;
    data_d     = '0;
    irq_d      = expired_q & ctrl_q.irq_en;
    tick       = 1'b0;

    if (rd) begin
      case (offset)
        TIMER_REG_CTRL:     data_d = data_width'(ctrl_q);
        TIMER_REG_LOAD:     data_d = load_q;
        TIMER_REG_PRESCALE: data_d = prescale_q;
        TIMER_REG_COUNT:    data_d = count_q;
        TIMER_REG_STATUS:   data_d = data_width'(expired_q);
        default:            data_d = '0;
      endcase
    end

    if (ctrl_q.enable) begin
      if (pre_cnt_q == prescale_q) begin
        tick      = 1'b1;
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + data_width'(1);
      end
    end

    if (status_wr && data_i[TIMER_STATUS_EXPIRED_BIT]) begin
      expired_d = 1'b0;
    end

    // Expiry is applied after the W1C so a coincident clear loses.
    if (tick && !load_wr) begin
      if (count_q != '0) begin
        count_d = count_q - data_width'(1);
      end else begin
        expired_d = 1'b1;
        if (ctrl_q.auto_reload) begin
          count_d = load_q;
        end else begin
          ctrl_d.enable = 1'b0;
        end
      end
    end

    if (ctrl_wr) begin
      ctrl_d = timer_ctrl_t'(data_i[TIMER_CTRL_IRQ_EN_BIT:TIMER_CTRL_ENABLE_BIT]);
    end

    if (load_wr) begin
      load_d    = data_i;
      count_d   = data_i;
      pre_cnt_d = '0;
    end

    if (prescale_wr) begin
      prescale_d = data_i;
      pre_cnt_d  = '0;
    end

    if (bus_reset_i) begin
      ctrl_d     = '0;
      load_d     = '0;
      prescale_d = PRESCALE_RESET;
      count_d    = '0;
      pre_cnt_d  = '0;
      expired_d  = 1'b0;
      data_d     = '0;
      irq_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_q     <= '0;
      load_q     <= '0;
      prescale_q <= PRESCALE_RESET;
      count_q    <= '0;
      pre_cnt_q  <= '0;
      expired_q  <= 1'b0;
      data_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      load_q     <= load_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      pre_cnt_q  <= pre_cnt_d;
      expired_q  <= expired_d;
      data_q     <= data_d;
      irq_q      <= irq_d;
    end
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_module_timer.sv
// Directed bench for module_timer: register-map vector table plus timed corner sequences.
module tb_module_timer;
  import cpu_reg_package::*;

  localparam logic [15:0] A_CTRL   = 16'h0100;
  localparam logic [15:0] A_LOAD   = 16'h0101;
  localparam logic [15:0] A_PRE    = 16'h0102;
  localparam logic [15:0] A_COUNT  = 16'h0103;
  localparam logic [15:0] A_STATUS = 16'h0104;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  module_timer_if bus ();

  module_timer #(.BASE_ADDRESS(16'h0100), .PRESCALE_RESET(16'h0000)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .bus_reset_i (bus.bus_reset),
    .we_i        (bus.we),
    .address_i   (bus.address),
    .data_i      (bus.wr_dat),
    .data_o      (bus.rd_dat),
    .irq_o       (bus.irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] dat;
    logic [15:0] exp_do;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge with outputs settled.
  task automatic step(input logic we, input logic [15:0] addr, input logic [15:0] dat);
    bus.we      = we;
    bus.address = addr;
    bus.wr_dat  = dat;
    @(posedge clk);
    @(negedge clk);
    bus.we      = 1'b0;
    bus.address = '0;
    bus.wr_dat  = '0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.bus_reset = 1'b0;
    bus.we        = 1'b0;
    bus.address   = '0;
    bus.wr_dat    = '0;

    vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, A_CTRL,   16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, A_PRE,    16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, A_LOAD,   16'h0003, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, A_LOAD,   16'h0000, 16'h0003, 1'b0};
    vecs[5]  = '{1'b0, A_COUNT,  16'h0000, 16'h0003, 1'b0};
    vecs[6]  = '{1'b1, A_CTRL,   16'h0001, 16'h0000, 1'b0};
    vecs[7]  = '{1'b0, A_COUNT,  16'h0000, 16'h0003, 1'b0};
    vecs[8]  = '{1'b0, A_COUNT,  16'h0000, 16'h0002, 1'b0};
    vecs[9]  = '{1'b0, A_COUNT,  16'h0000, 16'h0001, 1'b0};
    vecs[10] = '{1'b0, A_COUNT,  16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{1'b0, A_STATUS, 16'h0000, 16'h0001, 1'b0};
    vecs[12] = '{1'b0, A_CTRL,   16'h0000, 16'h0000, 1'b0};
    vecs[13] = '{1'b0, A_COUNT,  16'h0000, 16'h0000, 1'b0};
    vecs[14] = '{1'b1, 16'h0105, 16'hFFFF, 16'h0000, 1'b0};
    vecs[15] = '{1'b0, 16'h00FF, 16'h0000, 16'h0000, 1'b0};
    vecs[16] = '{1'b0, A_CTRL,   16'h0000, 16'h0000, 1'b0};
    vecs[17] = '{1'b1, A_STATUS, 16'h0001, 16'h0000, 1'b0};
    vecs[18] = '{1'b0, A_STATUS, 16'h0000, 16'h0000, 1'b0};
    vecs[19] = '{1'b1, A_CTRL,   16'hFFFE, 16'h0000, 1'b0};
    vecs[20] = '{1'b0, A_CTRL,   16'h0000, 16'h0006, 1'b0};
    vecs[21] = '{1'b1, A_CTRL,   16'h0000, 16'h0000, 1'b0};
    vecs[22] = '{1'b1, A_COUNT,  16'h0005, 16'h0000, 1'b0};
    vecs[23] = '{1'b0, A_COUNT,  16'h0000, 16'h0000, 1'b0};
    vecs[24] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[25] = '{1'b0, A_LOAD,   16'h0000, 16'h0003, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_data_o", bus.rd_dat, 16'h0000);
    chk("reset_irq_o", {15'b0, bus.irq}, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    // Register map, countdown 3..0 with enable clear, out-of-range and read-only checks.
    for (int i = 0; i < 26; i++) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].dat);
      chk($sformatf("vec%0d_data_o", i), bus.rd_dat, vecs[i].exp_do);
      chk($sformatf("vec%0d_irq_o", i), {15'b0, bus.irq}, {15'b0, vecs[i].exp_irq});
    end

    // Auto-reload with PRESCALE=2: expiry every 6 cycles, irq one cycle behind.
    step(1'b1, A_PRE, 16'h0002);
    step(1'b1, A_LOAD, 16'h0001);
    step(1'b1, A_CTRL, 16'h0007);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, A_STATUS, 16'h0000);
      chk($sformatf("ar_status_e%0d", k), bus.rd_dat, (k == 7) ? 16'h0001 : 16'h0000);
      chk($sformatf("ar_irq_e%0d", k), {15'b0, bus.irq}, (k == 7) ? 16'h0001 : 16'h0000);
    end
    step(1'b0, A_COUNT, 16'h0000);
    chk("ar_count_reload", bus.rd_dat, 16'h0001);
    step(1'b1, A_STATUS, 16'h0001);
    step(1'b0, A_STATUS, 16'h0000);
    chk("w1c_cleared", bus.rd_dat, 16'h0000);
    chk("w1c_irq_low", {15'b0, bus.irq}, 16'h0000);
    step(1'b0, A_COUNT, 16'h0000);
    chk("ar_count_zero", bus.rd_dat, 16'h0000);
    step(1'b1, A_STATUS, 16'h0001);
    step(1'b0, A_STATUS, 16'h0000);
    chk("w1c_vs_expiry", bus.rd_dat, 16'h0001);
    step(1'b1, A_STATUS, 16'h0001);
    step(1'b0, A_STATUS, 16'h0000);
    chk("w1c_late", bus.rd_dat, 16'h0000);
    step(1'b0, 16'h0000, 16'h0000);
    step(1'b0, A_STATUS, 16'h0000);
    chk("ar_pre_expiry", bus.rd_dat, 16'h0000);
    step(1'b0, A_STATUS, 16'h0000);
    step(1'b0, A_STATUS, 16'h0000);
    chk("ar_second_expiry", bus.rd_dat, 16'h0001);

    // Soft reset mid-countdown, with a write on the same cycle that must be dropped.
    step(1'b1, A_LOAD, 16'h0010);
    step(1'b0, 16'h0000, 16'h0000);
    bus.bus_reset = 1'b1;
    step(1'b1, A_CTRL, 16'h0007);
    bus.bus_reset = 1'b0;
    chk("sr_irq", {15'b0, bus.irq}, 16'h0000);
    step(1'b0, A_CTRL, 16'h0000);
    chk("sr_ctrl", bus.rd_dat, 16'h0000);
    step(1'b0, A_LOAD, 16'h0000);
    chk("sr_load", bus.rd_dat, 16'h0000);
    step(1'b0, A_PRE, 16'h0000);
    chk("sr_prescale", bus.rd_dat, 16'h0000);
    step(1'b0, A_COUNT, 16'h0000);
    chk("sr_count", bus.rd_dat, 16'h0000);
    repeat (30) step(1'b0, 16'h0000, 16'h0000);
    step(1'b0, A_STATUS, 16'h0000);
    chk("sr_no_expiry", bus.rd_dat, 16'h0000);
    chk("sr_no_irq", {15'b0, bus.irq}, 16'h0000);

    // Async reset in the middle of a clock phase while data_o and irq_o are high.
    step(1'b1, A_LOAD, 16'h0000);
    step(1'b1, A_CTRL, 16'h0007);
    step(1'b0, A_CTRL, 16'h0000);
    step(1'b0, A_CTRL, 16'h0000);
    chk("ar_pre_data", bus.rd_dat, 16'h0007);
    chk("ar_pre_irq", {15'b0, bus.irq}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    chk("async_data_o", bus.rd_dat, 16'h0000);
    chk("async_irq_o", {15'b0, bus.irq}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, A_CTRL, 16'h0000);
    chk("post_rst_ctrl", bus.rd_dat, 16'h0000);
    repeat (10) step(1'b0, 16'h0000, 16'h0000);
    step(1'b0, A_STATUS, 16'h0000);
    chk("post_rst_status", bus.rd_dat, 16'h0000);
    chk("post_rst_irq", {15'b0, bus.irq}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_timer.md
MODULE_TIMER -- requirements
Module: module_timer

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 16'h0100, first register address; BASE_ADDRESS SHALL be nonzero.
REQ-002 SHALL have parameter PRESCALE_RESET, default 0, reset value of the PRESCALE register.
REQ-003 SHALL have port clk_i, input, 1, destination-domain clock; the only clock.
REQ-004 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port bus_reset_i, input, 1, pulsed bus reset flag from the CDC stage.
REQ-006 SHALL have port we_i, input, 1, write strobe, valid only with a transaction strobe.
REQ-007 SHALL have port address_i, input, address_width, bus address; all-zero when idle.
REQ-008 SHALL have port data_i, input, data_width, write data.
REQ-009 SHALL have port data_o, output, data_width, read data returned to the CDC stage.
REQ-010 SHALL have port irq_o, output, 1, registered interrupt request.

Function
REQ-011 SHALL decode five registers at BASE_ADDRESS+0..+4: CTRL, LOAD, PRESCALE, COUNT, STATUS.
- CTRL bits: [0] enable, [1] auto_reload, [2] irq_en; other bits read 0.
- COUNT is read-only.
- STATUS bit [0] is expired, write-1-to-clear.
REQ-012 SHALL treat we_i=1 with an in-range address as a write, committed at that clock edge.
REQ-013 SHALL treat we_i=0 with an in-range address as a read.
REQ-014 SHALL register read data so it is valid on data_o exactly one cycle after the read cycle, matching the CDC capture cycle; data_o SHALL be 0 on all other cycles.
REQ-015 SHALL give reads no side effects; idle-bus aliasing to address 0 SHALL therefore never alter state.
REQ-016 SHALL make out-of-range accesses produce no state change, with data_o=0.
REQ-017 SHALL run a prescale counter 0..PRESCALE while enable=1 and emit a one-cycle tick at wrap; PRESCALE=0 SHALL tick every cycle.
REQ-018 SHALL act on each tick as follows:
- COUNT>0: decrement COUNT.
- COUNT=0: set expired; with auto_reload=1 load COUNT from LOAD, otherwise clear enable and hold COUNT at 0.
REQ-019 SHALL make a write to LOAD copy data_i into COUNT and clear the prescale counter; this write SHALL take priority over a same-cycle tick.
REQ-020 SHALL make a write to PRESCALE clear the prescale counter.
REQ-021 SHALL give a same-cycle STATUS W1C and expiry event priority to the expiry: expired ends at 1.
REQ-022 SHALL give a same-cycle CTRL write and tick-driven enable clear priority to the CTRL write value.
REQ-023 SHALL drive irq_o as a register of (expired AND irq_en), lagging by one cycle.
REQ-024 SHALL wrap COUNT and the prescale counter modulo 2^data_width, with no saturation logic.

Reset
REQ-025 SHALL on reset_n_i low, asynchronously, set:
- CTRL, LOAD, COUNT, STATUS, prescale counter: 0.
- PRESCALE: PRESCALE_RESET.
- data_o, irq_o: 0.
REQ-026 SHALL treat bus_reset_i=1 as a synchronous soft reset to the same values; the accompanying access SHALL be ignored.
REQ-027 SHALL discard a countdown interrupted by reset at any point, with no tick or expiry after release.

Structure
REQ-028 SHALL take address_width and data_width from cpu_reg_package.
REQ-029 SHALL add the register offset constants and CTRL bit indices to cpu_reg_package.
REQ-030 SHALL be a single module with no sub-module; the prescaler is inline.

Verification
REQ-031 SHALL verify: PRESCALE=0, LOAD=3, CTRL=3'b001 -> COUNT reads 3,2,1,0; expired=1 on the 4th tick; enable clears; irq_o stays 0.
REQ-032 SHALL verify: PRESCALE=2, LOAD=1, CTRL=3'b111 -> expiry every 6 cycles; COUNT reloads 1; irq_o rises one cycle after expired.
REQ-033 SHALL verify: STATUS W1C on the same cycle as expiry -> expired remains 1; a W1C one cycle later -> expired 0.
REQ-034 SHALL verify: a read of COUNT at BASE_ADDRESS+3 -> data_o correct on the next cycle and 0 on the cycles before and after; idle bus cycles leave all state unchanged.
REQ-035 SHALL verify: bus_reset_i pulse mid-countdown -> all registers revert to reset values and no expiry follows.
REQ-036 SHALL verify: reset_n_i asserted asynchronously mid-cycle -> outputs go to 0 immediately.
